// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture write-side sequencer.
//   capture_state_t : sequencer states
//   DATA_WIDTH_DEF  : default ADC sample width
//   ADDR_WIDTH_DEF  : default sample-buffer address width
//   trig_cond()     : level-crossing test between two consecutive samples
package adc_capture_pkg;

   localparam int DATA_WIDTH_DEF = 12;
   localparam int ADDR_WIDTH_DEF = 12;

   typedef enum logic [2:0] {
      IDLE,
      PRETRIG,
      ARMED,
      POSTTRIG,
      DONE
   } capture_state_t;

   // Operands arrive zero-extended so any sample width up to 32 bits fits;
   // unsigned ordering is preserved by the extension.
   function automatic logic trig_cond(input logic [31:0] prev,
                                      input logic [31:0] cur,
                                      input logic [31:0] level,
                                      input logic        rising);
      if (rising)
         return (prev < level) && (cur >= level);
      else
         return (prev >= level) && (cur < level);
   endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Sample stream in / buffer write port out of the capture sequencer.
//   sample_valid, sample_data        : ADC stream into the sequencer
//   write_en, write_addr, write_data : sample buffer write port
// master = sequencer side, slave = source/buffer side.
interface adc_capture_ctrl_if #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 12
);
   logic                  sample_valid;
   logic [DATA_WIDTH-1:0] sample_data;
   logic                  write_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;

   modport master (
      input  sample_valid,
      input  sample_data,
      output write_en,
      output write_addr,
      output write_data
   );

   modport slave (
      output sample_valid,
      output sample_data,
      input  write_en,
      input  write_addr,
      input  write_data
   );
endinterface

// File: rtl/adc_trigger_detect.sv
// Level-crossing detector. Remembers the last accepted sample and flags a
// crossing on the current one; hit is combinational, aligned with the sample.
//   clock, reset  : system clock, synchronous active-high reset
//   clear         : forget the previous sample (new capture)
//   sample_en     : a sample is being accepted this cycle
//   sample_data   : current sample
//   level, rising : threshold and crossing direction
//   hit           : crossing on the current sample
module adc_trigger_detect
   import adc_capture_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  sample_en,
   input  logic [DATA_WIDTH-1:0] sample_data,
   input  logic [DATA_WIDTH-1:0] level,
   input  logic                  rising,
   output logic                  hit
);

   logic [DATA_WIDTH-1:0] prev_q;
   logic                  prev_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q     <= '0;
         prev_valid <= 1'b0;
      end else if (clear) begin
         prev_valid <= 1'b0;
      end else if (sample_en) begin
         prev_q     <= sample_data;
         prev_valid <= 1'b1;
      end
   end

   assign hit = sample_en && prev_valid &&
                trig_cond(32'(prev_q), 32'(sample_data), 32'(level), rising);

endmodule

// File: rtl/adc_capture_ctrl.sv
// Write-side sequencer for the dual-port ADC sample buffer. Streams samples
// into the buffer as a circular buffer, keeps a programmable pre-trigger
// history, fires on a level crossing and stops after the post-trigger depth.
//   clock, reset               : system clock, synchronous active-high reset
//   arm, abort                 : start / cancel a capture (single-cycle pulses)
//   bus                        : sample stream in, buffer write port out
//   trig_level, trig_rising    : trigger threshold and direction
//   pretrig_len, posttrig_len  : window depths before/after the trigger sample
//   busy, triggered, done      : status
//   trig_addr, start_addr      : trigger sample and oldest window sample
// Optional build macro ADC_CAPTURE_EXT_TRIG_EN adds ext_trig / trig_sel
// (trig_sel=1 selects ext_trig instead of the level comparator).
//
// state    | meaning
// IDLE     | no capture, samples dropped
// PRETRIG  | filling pre-trigger history, trigger not evaluated
// ARMED    | writing freely, waiting for the trigger
// POSTTRIG | writing post-trigger samples
// DONE     | window complete, results held until next arm
module adc_capture_ctrl
   import adc_capture_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int BUFFER_SIZE = 2 ** ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  arm,
   input  logic                  abort,
   adc_capture_ctrl_if.master    bus,
   input  logic [DATA_WIDTH-1:0] trig_level,
   input  logic                  trig_rising,
   input  logic [ADDR_WIDTH-1:0] pretrig_len,
   input  logic [ADDR_WIDTH-1:0] posttrig_len,
`ifdef ADC_CAPTURE_EXT_TRIG_EN
   input  logic                  ext_trig,
   input  logic                  trig_sel,
`endif
   output logic                  busy,
   output logic                  triggered,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic [ADDR_WIDTH-1:0] start_addr
);

   localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(BUFFER_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

   capture_state_t        state, state_nx;
   logic [ADDR_WIDTH-1:0] ptr, cnt, pre_len, eff_post, eff_post_in;
   logic [DATA_WIDTH-1:0] level_q;
   logic                  rising_q;
   logic [ADDR_WIDTH:0]   len_sum;
   logic                  arm_take, wr_take, fire, lvl_hit, busy_st;

   // Post-trigger depth is clamped so the whole window fits in the buffer.
   assign len_sum     = {1'b0, pretrig_len} + {1'b0, posttrig_len};
   assign eff_post_in = (len_sum > {1'b0, MAX_LEN}) ? (MAX_LEN - pretrig_len)
                                                    : posttrig_len;

   assign busy_st = (state == PRETRIG) || (state == ARMED) || (state == POSTTRIG);
   // A sample coinciding with abort is not written.
   assign wr_take = busy_st && bus.sample_valid && !abort;

   adc_trigger_detect #(.DATA_WIDTH(DATA_WIDTH)) u_detect (
      .clock       (clock),
      .reset       (reset),
      .clear       (arm_take),
      .sample_en   (wr_take),
      .sample_data (bus.sample_data),
      .level       (level_q),
      .rising      (rising_q),
      .hit         (lvl_hit)
   );

`ifdef ADC_CAPTURE_EXT_TRIG_EN
   assign fire = (state == ARMED) && (trig_sel ? (wr_take && ext_trig) : lvl_hit);
`else
   assign fire = (state == ARMED) && lvl_hit;
`endif

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      arm_take = 1'b0;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (arm) begin
                  arm_take = 1'b1;
                  state_nx = (pretrig_len == '0) ? ARMED : PRETRIG;
               end
            end
            PRETRIG:  if (wr_take && (cnt + CNT_ONE == pre_len)) state_nx = ARMED;
            ARMED:    if (fire) state_nx = (eff_post == '0) ? DONE : POSTTRIG;
            POSTTRIG: if (wr_take && (cnt + CNT_ONE == eff_post)) state_nx = DONE;
            default:  state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bus.write_en   <= 1'b0;
         bus.write_addr <= '0;
         bus.write_data <= '0;
         ptr            <= '0;
         cnt            <= '0;
         pre_len        <= '0;
         eff_post       <= '0;
         level_q        <= '0;
         rising_q       <= 1'b0;
         triggered      <= 1'b0;
         trig_addr      <= '0;
         start_addr     <= '0;
      end else begin
         bus.write_en <= wr_take;
         if (wr_take) begin
            bus.write_addr <= ptr;
            bus.write_data <= bus.sample_data;
            ptr            <= ptr + CNT_ONE;
         end
         if (arm_take) begin
            ptr       <= '0;
            cnt       <= '0;
            pre_len   <= pretrig_len;
            eff_post  <= eff_post_in;
            level_q   <= trig_level;
            rising_q  <= trig_rising;
            triggered <= 1'b0;
         end else if (abort) begin
            triggered <= 1'b0;
         end else begin
            if (fire) begin
               triggered <= 1'b1;
               trig_addr <= ptr;
               cnt       <= '0;
            end else if (wr_take) begin
               cnt <= cnt + CNT_ONE;
            end
            // Trigger address may be landing this same cycle when posttrig is 0.
            if (state_nx == DONE && state != DONE)
               start_addr <= (fire ? ptr : trig_addr) - pre_len;
         end
      end
   end

   assign busy = busy_st;
   assign done = (state == DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
module tb_adc_capture_ctrl;

   logic        clock = 1'b0;
   logic        reset, arm, abort, trig_rising;
   logic [11:0] trig_level, pretrig_len, posttrig_len;
   logic        busy, triggered, done;
   logic [11:0] trig_addr, start_addr;
`ifdef ADC_CAPTURE_EXT_TRIG_EN
   logic        ext_trig = 1'b0;
   logic        trig_sel = 1'b0;
`endif

   int          total = 0;
   int          bad   = 0;
   int          wr_count = 0;
   logic [11:0] exp_ptr = '0;

   adc_capture_ctrl_if #(.DATA_WIDTH(12), .ADDR_WIDTH(12)) bus ();

   adc_capture_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .arm          (arm),
      .abort        (abort),
      .bus          (bus),
      .trig_level   (trig_level),
      .trig_rising  (trig_rising),
      .pretrig_len  (pretrig_len),
      .posttrig_len (posttrig_len),
`ifdef ADC_CAPTURE_EXT_TRIG_EN
      .ext_trig     (ext_trig),
      .trig_sel     (trig_sel),
`endif
      .busy         (busy),
      .triggered    (triggered),
      .done         (done),
      .trig_addr    (trig_addr),
      .start_addr   (start_addr)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Every buffer write must land on the next circular address.
   always @(negedge clock) begin
      if (bus.write_en === 1'b1) begin
         check("waddr_seq", bus.write_addr, exp_ptr);
         exp_ptr  = exp_ptr + 12'd1;
         wr_count = wr_count + 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [11:0] d);
      bus.sample_valid = 1'b1;
      bus.sample_data  = d;
      tick();
      bus.sample_valid = 1'b0;
   endtask

   task automatic do_arm(input logic [11:0] pre, input logic [11:0] post,
                         input logic [11:0] lvl, input logic rise);
      pretrig_len  = pre;
      posttrig_len = post;
      trig_level   = lvl;
      trig_rising  = rise;
      arm          = 1'b1;
      tick();
      arm      = 1'b0;
      exp_ptr  = '0;
      wr_count = 0;
   endtask

   initial begin
      reset = 1'b1; arm = 1'b0; abort = 1'b0;
      trig_level = '0; trig_rising = 1'b1; pretrig_len = '0; posttrig_len = '0;
      bus.sample_valid = 1'b0; bus.sample_data = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wen", bus.write_en, 0);
      check("rst_trig", triggered, 0);

      // basic ramp capture; an arm while busy must be ignored
      do_arm(12'd4, 12'd3, 12'd100, 1'b1);
      check("basic_busy", busy, 1);
      for (int i = 0; i < 4; i++) send(12'(20 * i));
      arm = 1'b1;
      send(12'd80);
      arm = 1'b0;
      check("basic_notrig", triggered, 0);
      send(12'd100);
      check("basic_trig", triggered, 1);
      check("basic_taddr", trig_addr, 5);
      check("basic_waddr", bus.write_addr, 5);
      check("basic_wdata", bus.write_data, 100);
      send(12'd120);
      send(12'd140);
      check("basic_notdone", done, 0);
      send(12'd160);
      check("basic_done", done, 1);
      check("basic_busy0", busy, 0);
      check("basic_start", start_addr, 1);
      send(12'd180);
      check("drop_wen", bus.write_en, 0);
      send(12'd200);
      check("basic_wcount", wr_count, 9);
      check("basic_hold", done, 1);

      // wrap-around capture
      do_arm(12'd10, 12'd5, 12'd100, 1'b1);
      for (int i = 0; i < 5000; i++) begin
         send(12'd0);
         if (i == 4095) check("wrap_hi", bus.write_addr, 4095);
         if (i == 4096) check("wrap_lo", bus.write_addr, 0);
      end
      check("wrap_notrig", triggered, 0);
      send(12'd200);
      check("wrap_taddr", trig_addr, 904);
      for (int i = 0; i < 4; i++) send(12'd200);
      check("wrap_notdone", done, 0);
      send(12'd200);
      check("wrap_done", done, 1);
      check("wrap_start", start_addr, 894);
      tick();
      check("wrap_wcount", wr_count, 5006);

      // crossing during pre-trigger fill is ignored
      do_arm(12'd8, 12'd4, 12'd100, 1'b1);
      for (int i = 0; i < 13; i++) begin
         send((i < 3 || (i >= 8 && i < 12)) ? 12'd50 : 12'd150);
         if (i == 11) check("early_notrig", triggered, 0);
      end
      check("early_trig", triggered, 1);
      check("early_taddr", trig_addr, 12);
      for (int i = 0; i < 4; i++) send(12'd150);
      check("early_done", done, 1);
      check("early_start", start_addr, 4);

      // abort in POSTTRIG, then simultaneous arm+abort
      do_arm(12'd2, 12'd10, 12'd100, 1'b1);
      send(12'd0); send(12'd0); send(12'd0); send(12'd200);
      check("abort_trig1", triggered, 1);
      send(12'd200); send(12'd200);
      abort = 1'b1;
      send(12'd200);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_wen", bus.write_en, 0);
      check("abort_trig", triggered, 0);
      arm = 1'b1; abort = 1'b1;
      send(12'd0);
      arm = 1'b0; abort = 1'b0;
      check("armabort_busy", busy, 0);
      send(12'd0);
      check("armabort_wen", bus.write_en, 0);
      check("abort_wcount", wr_count, 6);

      // clamp with stalled sample stream
      do_arm(12'd4000, 12'd200, 12'd100, 1'b1);
      for (int i = 0; i < 4000; i++) begin
         send(12'd0);
         tick();
      end
      check("stall_wen", bus.write_en, 0);
      send(12'd0); tick();
      send(12'd200); tick();
      check("clamp_taddr", trig_addr, 4001);
      for (int i = 0; i < 94; i++) begin
         send(12'd200);
         tick();
      end
      check("clamp_notdone", done, 0);
      send(12'd200);
      check("clamp_done", done, 1);
      check("clamp_start", start_addr, 1);
      tick();
      check("clamp_wcount", wr_count, 4097);

      // reset mid-capture
      do_arm(12'd2, 12'd3, 12'd100, 1'b1);
      send(12'd50); send(12'd50); send(12'd50);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_busy", busy, 0);
      check("mrst_wen", bus.write_en, 0);
      check("mrst_waddr", bus.write_addr, 0);
      check("mrst_wdata", bus.write_data, 0);
      check("mrst_trig", triggered, 0);
      check("mrst_done", done, 0);
      check("mrst_taddr", trig_addr, 0);
      check("mrst_start", start_addr, 0);

      // falling edge, no pretrig, no posttrig
      do_arm(12'd0, 12'd0, 12'd100, 1'b0);
      check("fall_busy", busy, 1);
      send(12'd200); send(12'd150); send(12'd100);
      check("fall_notrig", triggered, 0);
      send(12'd50);
      check("fall_taddr", trig_addr, 3);
      check("fall_done", done, 1);
      check("fall_start", start_addr, 3);

      // first sample after arm has no predecessor
      do_arm(12'd0, 12'd1, 12'd100, 1'b1);
      send(12'd150);
      check("first_notrig", triggered, 0);
      send(12'd50); send(12'd120);
      check("first_taddr", trig_addr, 2);
      check("first_notdone", done, 0);
      send(12'd130);
      check("first_done", done, 1);
      check("first_start", start_addr, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Write-side sequencer placed directly upstream of the dual-port ADC sample buffer.
- Accepts the ADC sample stream and drives the buffer's write_en, write_addr and data_in as a circular buffer.
- Runs a level-crossing trigger with programmable pre-trigger and post-trigger depths.
- On completion, reports trig_addr and start_addr so the readout side can unroll the captured window.

Parameters:
DATA_WIDTH, 12, ADC sample width; must match the buffer.
ADDR_WIDTH, 12, buffer address width.
BUFFER_SIZE, 4096, buffer depth; must equal 2**ADDR_WIDTH.

Ports:
clock  in  1  system clock; the same clock as the buffer.
reset  in  1  synchronous, active-high.
arm  in  1  single-cycle pulse that starts a capture.
abort  in  1  single-cycle pulse that cancels a capture.
sample_valid  in  1  qualifies sample_data.
sample_data  in  DATA_WIDTH  ADC sample, unsigned.
trig_level  in  DATA_WIDTH  trigger threshold, unsigned.
trig_rising  in  1  1 = rising crossing, 0 = falling crossing.
pretrig_len  in  ADDR_WIDTH  number of samples kept before the trigger.
posttrig_len  in  ADDR_WIDTH  number of samples kept after the trigger sample.
write_en  out  1  to the buffer's write_en.
write_addr  out  ADDR_WIDTH  to the buffer's write_addr.
write_data  out  DATA_WIDTH  to the buffer's data_in.
busy  out  1  high in PRETRIG, ARMED and POSTTRIG.
triggered  out  1  set when the trigger fires; cleared on arm, abort or reset.
done  out  1  held high in DONE; cleared on arm, abort or reset.
trig_addr  out  ADDR_WIDTH  buffer address of the trigger sample.
start_addr  out  ADDR_WIDTH  address of the oldest sample in the window.

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE. Every output and internal register is 0: write_en, write_addr, write_data, busy, triggered, done, trig_addr, start_addr, the pointer and the counters. Reset mid-capture discards the capture immediately.
- Write path:
  - When busy and sample_valid are both high, the next cycle has write_en=1, write_data=sample_data and write_addr=ptr. Latency is 1 cycle.
  - ptr increments after each write and wraps modulo 2**ADDR_WIDTH.
  - write_en is 0 in IDLE and DONE.
- Arm:
  - arm is accepted only in IDLE or DONE; it is ignored while busy.
  - On accept: latch pretrig_len, posttrig_len, trig_level and trig_rising. Clear ptr, the counters, done, triggered and the previous-sample-valid flag.
  - Post-trigger clamp: if pretrig_len + posttrig_len > BUFFER_SIZE-1, the effective posttrig = BUFFER_SIZE-1-pretrig_len.
- State machine:
  - IDLE --arm--> PRETRIG, or directly to ARMED when pretrig_len=0.
  - PRETRIG: count written samples; once the count reaches pretrig_len, go to ARMED. The trigger is not evaluated in PRETRIG.
  - ARMED: keep writing, wrapping freely.
    - Trigger condition, rising: prev < level and cur >= level.
    - Trigger condition, falling: prev >= level and cur < level.
    - prev is the last valid sample. The first sample after arm has no prev and cannot trigger.
    - On a trigger the sample is still written. trig_addr is set to its address and triggered=1. Next state is POSTTRIG, or DONE when the effective posttrig=0.
  - POSTTRIG: count written samples; after the effective posttrig count is reached, go to DONE.
  - DONE: set done=1, busy=0 and start_addr = (trig_addr - pretrig_len) mod 2**ADDR_WIDTH. Outputs hold until the next arm.
- abort in any busy state goes to IDLE on the next cycle. write_en is 0 from that cycle and done stays 0.
- Simultaneous arm and abort: abort wins.
- Samples arriving while in IDLE or DONE are dropped.
- Gaps in sample_valid stall all counters. No state advances without a valid sample.

Optional Feature:
- Macro: ADC_CAPTURE_EXT_TRIG_EN.
- Defined: adds the input ext_trig (1 bit) and the input trig_sel (1 bit, 1 = external).
  - When trig_sel=1, a high ext_trig sampled together with a valid sample in ARMED triggers on that sample.
  - The level comparator is ignored while trig_sel=1.
- Undefined: those ports do not exist; only the level trigger is available.

Decomposition:
- Package adc_capture_pkg holds:
  - the state enum capture_state_t (IDLE, PRETRIG, ARMED, POSTTRIG, DONE);
  - the DATA_WIDTH and ADDR_WIDTH defaults;
  - a trig_cond function (prev, cur, level, rising).
- Sub-module adc_trigger_detect holds the prev-sample register, the prev-valid flag and the comparator. It outputs a 1-cycle hit aligned with the sample.

Test Plan:
- Basic capture: pretrig=4, posttrig=3, level=100, rising. Ramp 0,20,40,…, one sample per clock. Required: trigger on 100 at address 5, start_addr=1, done after 3 more writes, and exactly 9 writes after the trigger has been armed.
- Wrap: pretrig=10, posttrig=5. Feed 5000 samples below level, then a crossing. Required: trig_addr = 5000 mod 4096 = 904, start_addr=894, and write_addr wraps from 4095 to 0 without a gap.
- Trigger before pretrig fills: pretrig=8. Feed a crossing at sample 3, then a second crossing at sample 12. Required: the first crossing is ignored and the trigger lands on sample 12.
- Abort and arm: abort while in POSTTRIG. Required: state returns to IDLE, done=0, and write_en=0 the next cycle. A simultaneous arm and abort leaves the block in IDLE.
- Clamp and stall: pretrig=4000, posttrig=200. Required: effective posttrig=95. With sample_valid toggling every other cycle, the counts still match exactly.
- Reset mid-capture: assert reset while in ARMED. Required: all outputs 0 on the next cycle, and a new arm works normally afterwards.
